controlador_transacao: RTL and testbench

CONTROLADOR_TRANSACAO -- requirements
Module: controlador_transacao

---
 rtl/controlador_transacao.sv | 158 +++++++++++++++
 tb/tb_controlador_transacao.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/controlador_transacao.sv
// Transaction controller for a vending machine.
// Handles product selection, checks the price against the external price
// memory, accumulates coins, dispenses the product, returns change, and
// cancels on request or after an inactivity timeout.
module controlador_transacao #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] codigo_in,
    input  logic       selecionar,
    input  logic [1:0] moeda,
    input  logic       cancelar,
    input  logic [3:0] valor_preco,
    input  logic       produto_existe,
    output logic [3:0] codigo_produto,
    output logic       liberar_produto,
    output logic [4:0] troco,
    output logic       troco_valido,
    output logic       erro_produto,
    output logic [4:0] credito,
    output logic [1:0] estado
);

    typedef enum logic [1:0] {
        ESPERA    = 2'b00,
        VERIFICA  = 2'b01,
        PAGAMENTO = 2'b10,
        ENTREGA   = 2'b11
    } estado_t;

    estado_t    estado_atual;
    estado_t    estado_prox;

    logic [3:0] preco;
    logic [3:0] preco_prox;
    logic [7:0] inativo;
    logic [7:0] inativo_prox;

    logic [3:0] codigo_prox;
    logic [4:0] credito_prox;
    logic [4:0] troco_prox;
    logic       troco_valido_prox;
    logic       liberar_prox;
    logic       erro_prox;

    logic [4:0] valor_moeda;
    logic [4:0] soma;
    logic [8:0] inativo_inc;
    logic       expirou;

    // Coin decoding to R$0.25 units, next credit and timeout detection.
    always_comb begin
        valor_moeda = '0;
        case (moeda)
            2'b01:   valor_moeda = 5'd1;
            2'b10:   valor_moeda = 5'd2;
            2'b11:   valor_moeda = 5'd4;
            default: valor_moeda = '0;
        endcase
        soma        = credito + valor_moeda;
        inativo_inc = {1'b0, inativo} + 9'd1;
        // An idle cycle that brings the counter to TIMEOUT cancels in that same edge.
        expirou     = (moeda == 2'b00) && (inativo_inc >= 9'(TIMEOUT));
    end

    // Next-state and next-output logic. All outputs are registered from these.
    always_comb begin
        estado_prox       = estado_atual;
        codigo_prox       = codigo_produto;
        credito_prox      = credito;
        preco_prox        = preco;
        inativo_prox      = inativo;
        troco_prox        = '0;
        troco_valido_prox = 1'b0;
        liberar_prox      = 1'b0;
        erro_prox         = 1'b0;

        case (estado_atual)
            ESPERA: begin
                if (selecionar) begin
                    codigo_prox  = codigo_in;
                    credito_prox = '0;
                    estado_prox  = VERIFICA;
                end
            end

            VERIFICA: begin
                if (produto_existe) begin
                    preco_prox   = valor_preco;
                    inativo_prox = '0;
                    if (valor_preco == 4'd0)
                        estado_prox = ENTREGA;
                    else
                        estado_prox = PAGAMENTO;
                end else begin
                    erro_prox   = 1'b1;
                    estado_prox = ESPERA;
                end
            end

            PAGAMENTO: begin
                if (cancelar || expirou) begin
                    troco_prox        = credito;
                    troco_valido_prox = 1'b1;
                    credito_prox      = '0;
                    inativo_prox      = '0;
                    estado_prox       = ESPERA;
                end else if (moeda != 2'b00) begin
                    credito_prox = soma;
                    inativo_prox = '0;
                    if (soma >= {1'b0, preco})
                        estado_prox = ENTREGA;
                end else begin
                    inativo_prox = inativo_inc[7:0];
                end
            end

            ENTREGA: begin
                liberar_prox      = 1'b1;
                troco_valido_prox = 1'b1;
                troco_prox        = credito - {1'b0, preco};
                credito_prox      = '0;
                estado_prox       = ESPERA;
            end

            default: estado_prox = ESPERA;
        endcase
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            estado_atual    <= ESPERA;
            codigo_produto  <= '0;
            credito         <= '0;
            preco           <= '0;
            inativo         <= '0;
            troco           <= '0;
            troco_valido    <= 1'b0;
            liberar_produto <= 1'b0;
            erro_produto    <= 1'b0;
        end else begin
            estado_atual    <= estado_prox;
            codigo_produto  <= codigo_prox;
            credito         <= credito_prox;
            preco           <= preco_prox;
            inativo         <= inativo_prox;
            troco           <= troco_prox;
            troco_valido    <= troco_valido_prox;
            liberar_produto <= liberar_prox;
            erro_produto    <= erro_prox;
        end
    end

    assign estado = estado_atual;

endmodule

// File: tb/tb_controlador_transacao.sv
// Directed self-checking bench for controlador_transacao (TIMEOUT = 8).
module tb_controlador_transacao;

    logic       clk;
    logic       rst;
    logic [3:0] codigo_in;
    logic       selecionar;
    logic [1:0] moeda;
    logic       cancelar;
    logic [3:0] valor_preco;
    logic       produto_existe;
    logic [3:0] codigo_produto;
    logic       liberar_produto;
    logic [4:0] troco;
    logic       troco_valido;
    logic       erro_produto;
    logic [4:0] credito;
    logic [1:0] estado;

    int unsigned n_cmp;
    int unsigned n_err;

    controlador_transacao #(.TIMEOUT(8)) dut (
        .clk            (clk),
        .rst            (rst),
        .codigo_in      (codigo_in),
        .selecionar     (selecionar),
        .moeda          (moeda),
        .cancelar       (cancelar),
        .valor_preco    (valor_preco),
        .produto_existe (produto_existe),
        .codigo_produto (codigo_produto),
        .liberar_produto(liberar_produto),
        .troco          (troco),
        .troco_valido   (troco_valido),
        .erro_produto   (erro_produto),
        .credito        (credito),
        .estado         (estado)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Price memory model: code -> (exists, price in R$0.25 units).
    always_comb begin
        produto_existe = 1'b1;
        valor_preco    = 4'd0;
        case (codigo_produto)
            4'b0000: valor_preco = 4'd4;
            4'b0100: valor_preco = 4'd8;
            4'b0101: valor_preco = 4'd2;
            4'b0010: valor_preco = 4'd0;
            4'b1111: valor_preco = 4'd15;
            default: begin produto_existe = 1'b0; valor_preco = 4'd0; end
        endcase
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        selecionar = 1'b0;
        moeda      = 2'b00;
        cancelar   = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; codigo_in = 4'd0; idle_inputs();
        tick(); tick();
        n_cmp++; if (estado !== 2'b00 || credito !== 5'd0 || codigo_produto !== 4'd0) begin n_err++; $display("FAIL reset_state: estado=%0d credito=%0d codigo=%0d required 0/0/0", estado, credito, codigo_produto); end
        n_cmp++; if ({liberar_produto, troco_valido, erro_produto} !== 3'b000 || troco !== 5'd0) begin n_err++; $display("FAIL reset_pulses: lib/tv/err=%b troco=%0d required 000/0", {liberar_produto, troco_valido, erro_produto}, troco); end
        rst = 1'b0;
        tick();
        n_cmp++; if (estado !== 2'b00) begin n_err++; $display("FAIL reset_idle: estado=%0d required 0", estado); end
    endtask

    task automatic test_compra_exata();
        codigo_in = 4'b0100; selecionar = 1'b1;
        tick();
        n_cmp++; if (estado !== 2'b01 || codigo_produto !== 4'b0100) begin n_err++; $display("FAIL exata_verifica: estado=%0d codigo=%0d required 1/4", estado, codigo_produto); end
        selecionar = 1'b0;
        tick();
        n_cmp++; if (estado !== 2'b10 || credito !== 5'd0) begin n_err++; $display("FAIL exata_pagamento: estado=%0d credito=%0d required 2/0", estado, credito); end
        moeda = 2'b11;
        tick();
        n_cmp++; if (estado !== 2'b10 || credito !== 5'd4) begin n_err++; $display("FAIL exata_moeda1: estado=%0d credito=%0d required 2/4", estado, credito); end
        tick();
        n_cmp++; if (estado !== 2'b11 || credito !== 5'd8) begin n_err++; $display("FAIL exata_moeda2: estado=%0d credito=%0d required 3/8", estado, credito); end
        moeda = 2'b00;
        tick();
        n_cmp++; if (liberar_produto !== 1'b1 || troco_valido !== 1'b1 || troco !== 5'd0 || credito !== 5'd0 || estado !== 2'b00) begin n_err++; $display("FAIL exata_entrega: lib=%b tv=%b troco=%0d credito=%0d estado=%0d required 1/1/0/0/0", liberar_produto, troco_valido, troco, credito, estado); end
        tick();
        n_cmp++; if (liberar_produto !== 1'b0 || troco_valido !== 1'b0) begin n_err++; $display("FAIL exata_pulso: lib=%b tv=%b required 0/0", liberar_produto, troco_valido); end
    endtask

    task automatic test_troco();
        codigo_in = 4'b0101; selecionar = 1'b1;
        tick();
        selecionar = 1'b0;
        tick();
        moeda = 2'b11;
        tick();
        n_cmp++; if (estado !== 2'b11 || credito !== 5'd4) begin n_err++; $display("FAIL troco_entrega: estado=%0d credito=%0d required 3/4", estado, credito); end
        moeda = 2'b00;
        tick();
        n_cmp++; if (troco !== 5'd2 || troco_valido !== 1'b1 || liberar_produto !== 1'b1) begin n_err++; $display("FAIL troco_valor: troco=%0d tv=%b lib=%b required 2/1/1", troco, troco_valido, liberar_produto); end
        tick();
        n_cmp++; if (troco !== 5'd0 || troco_valido !== 1'b0) begin n_err++; $display("FAIL troco_zera: troco=%0d tv=%b required 0/0", troco, troco_valido); end
    endtask

    task automatic test_produto_inexistente();
        codigo_in = 4'b0001; selecionar = 1'b1;
        tick();
        selecionar = 1'b0;
        n_cmp++; if (erro_produto !== 1'b0 || estado !== 2'b01) begin n_err++; $display("FAIL erro_cedo: err=%b estado=%0d required 0/1", erro_produto, estado); end
        tick();
        n_cmp++; if (erro_produto !== 1'b1 || estado !== 2'b00 || liberar_produto !== 1'b0) begin n_err++; $display("FAIL erro_pulso: err=%b estado=%0d lib=%b required 1/0/0", erro_produto, estado, liberar_produto); end
        tick();
        n_cmp++; if (erro_produto !== 1'b0 || estado !== 2'b00 || codigo_produto !== 4'b0001) begin n_err++; $display("FAIL erro_fim: err=%b estado=%0d codigo=%0d required 0/0/1", erro_produto, estado, codigo_produto); end
    endtask

    task automatic test_cancelar();
        codigo_in = 4'b0000; selecionar = 1'b1;
        tick();
        selecionar = 1'b0;
        tick();
        moeda = 2'b10;
        tick();
        n_cmp++; if (credito !== 5'd2 || estado !== 2'b10) begin n_err++; $display("FAIL cancel_credito: credito=%0d estado=%0d required 2/2", credito, estado); end
        moeda = 2'b11; cancelar = 1'b1;
        tick();
        idle_inputs();
        n_cmp++; if (troco !== 5'd2 || troco_valido !== 1'b1 || liberar_produto !== 1'b0 || credito !== 5'd0 || estado !== 2'b00) begin n_err++; $display("FAIL cancel_troco: troco=%0d tv=%b lib=%b credito=%0d estado=%0d required 2/1/0/0/0", troco, troco_valido, liberar_produto, credito, estado); end
        // Cancel with no credit still pulses troco_valido with troco=0.
        codigo_in = 4'b0000; selecionar = 1'b1;
        tick();
        selecionar = 1'b0;
        tick();
        cancelar = 1'b1;
        tick();
        cancelar = 1'b0;
        n_cmp++; if (troco !== 5'd0 || troco_valido !== 1'b1 || liberar_produto !== 1'b0 || estado !== 2'b00) begin n_err++; $display("FAIL cancel_zero: troco=%0d tv=%b lib=%b estado=%0d required 0/1/0/0", troco, troco_valido, liberar_produto, estado); end
    endtask

    task automatic test_timeout();
        codigo_in = 4'b0000; selecionar = 1'b1;
        tick();
        selecionar = 1'b0;
        tick();
        moeda = 2'b01;
        tick();
        moeda = 2'b00;
        n_cmp++; if (credito !== 5'd1) begin n_err++; $display("FAIL timeout_credito: credito=%0d required 1", credito); end
        for (int i = 0; i < 7; i++) tick();
        n_cmp++; if (estado !== 2'b10 || troco_valido !== 1'b0) begin n_err++; $display("FAIL timeout_cedo: estado=%0d tv=%b required 2/0", estado, troco_valido); end
        tick();
        n_cmp++; if (troco !== 5'd1 || troco_valido !== 1'b1 || estado !== 2'b00 || liberar_produto !== 1'b0) begin n_err++; $display("FAIL timeout_troco: troco=%0d tv=%b estado=%0d lib=%b required 1/1/0/0", troco, troco_valido, estado, liberar_produto); end
    endtask

    task automatic test_preco_zero();
        codigo_in = 4'b0010; selecionar = 1'b1;
        tick();
        selecionar = 1'b0;
        tick();
        n_cmp++; if (estado !== 2'b11) begin n_err++; $display("FAIL zero_entrega: estado=%0d required 3", estado); end
        tick();
        n_cmp++; if (liberar_produto !== 1'b1 || troco !== 5'd0 || troco_valido !== 1'b1 || estado !== 2'b00) begin n_err++; $display("FAIL zero_libera: lib=%b troco=%0d tv=%b estado=%0d required 1/0/1/0", liberar_produto, troco, troco_valido, estado); end
    endtask

    task automatic test_moedas_ignoradas();
        codigo_in = 4'b0101; selecionar = 1'b1; moeda = 2'b11; cancelar = 1'b1;
        tick();
        selecionar = 1'b0; cancelar = 1'b0;
        n_cmp++; if (estado !== 2'b01 || codigo_produto !== 4'b0101) begin n_err++; $display("FAIL ign_espera: estado=%0d codigo=%0d required 1/5", estado, codigo_produto); end
        tick();
        n_cmp++; if (estado !== 2'b10 || credito !== 5'd0) begin n_err++; $display("FAIL ign_verifica: estado=%0d credito=%0d required 2/0", estado, credito); end
        moeda = 2'b00; codigo_in = 4'b0100; selecionar = 1'b1;
        tick();
        selecionar = 1'b0;
        n_cmp++; if (codigo_produto !== 4'b0101 || estado !== 2'b10) begin n_err++; $display("FAIL ign_selecao: codigo=%0d estado=%0d required 5/2", codigo_produto, estado); end
        moeda = 2'b01;
        tick();
        n_cmp++; if (credito !== 5'd1 || estado !== 2'b10) begin n_err++; $display("FAIL ign_moeda1: credito=%0d estado=%0d required 1/2", credito, estado); end
        tick();
        n_cmp++; if (credito !== 5'd2 || estado !== 2'b11) begin n_err++; $display("FAIL ign_limite: credito=%0d estado=%0d required 2/3", credito, estado); end
        moeda = 2'b11; selecionar = 1'b1; codigo_in = 4'b0000;
        tick();
        idle_inputs();
        n_cmp++; if (liberar_produto !== 1'b1 || troco !== 5'd0 || credito !== 5'd0 || estado !== 2'b00) begin n_err++; $display("FAIL ign_entrega: lib=%b troco=%0d credito=%0d estado=%0d required 1/0/0/0", liberar_produto, troco, credito, estado); end
    endtask

    task automatic test_credito_maximo();
        codigo_in = 4'b1111; selecionar = 1'b1;
        tick();
        selecionar = 1'b0;
        tick();
        moeda = 2'b11;
        tick(); tick(); tick();
        n_cmp++; if (credito !== 5'd12 || estado !== 2'b10) begin n_err++; $display("FAIL max_parcial: credito=%0d estado=%0d required 12/2", credito, estado); end
        tick();
        moeda = 2'b00;
        n_cmp++; if (credito !== 5'd16 || estado !== 2'b11) begin n_err++; $display("FAIL max_total: credito=%0d estado=%0d required 16/3", credito, estado); end
        tick();
        n_cmp++; if (troco !== 5'd1 || liberar_produto !== 1'b1) begin n_err++; $display("FAIL max_troco: troco=%0d lib=%b required 1/1", troco, liberar_produto); end
    endtask

    task automatic test_back_to_back();
        // Select right after a delivery pulse; the previous result must not linger.
        codigo_in = 4'b0101; selecionar = 1'b1;
        tick();
        selecionar = 1'b0;
        tick();
        moeda = 2'b10;
        tick();
        moeda = 2'b00; codigo_in = 4'b0000; selecionar = 1'b1;
        tick();
        n_cmp++; if (liberar_produto !== 1'b1 || troco !== 5'd0 || estado !== 2'b00) begin n_err++; $display("FAIL b2b_entrega: lib=%b troco=%0d estado=%0d required 1/0/0", liberar_produto, troco, estado); end
        tick();
        selecionar = 1'b0;
        n_cmp++; if (estado !== 2'b01 || codigo_produto !== 4'b0000 || liberar_produto !== 1'b0) begin n_err++; $display("FAIL b2b_selecao: estado=%0d codigo=%0d lib=%b required 1/0/0", estado, codigo_produto, liberar_produto); end
        tick();
        moeda = 2'b01;
        tick();
        moeda = 2'b10;
        tick();
        moeda = 2'b00;
        n_cmp++; if (credito !== 5'd3 || estado !== 2'b10) begin n_err++; $display("FAIL b2b_credito: credito=%0d estado=%0d required 3/2", credito, estado); end
    endtask

    task automatic test_reset_meio();
        // Continues from test_back_to_back: code 0000, credito 3 in PAGAMENTO.
        #2;
        rst = 1'b1;
        #1;
        n_cmp++; if (estado !== 2'b00 || credito !== 5'd0 || codigo_produto !== 4'd0 || troco !== 5'd0 || {liberar_produto, troco_valido, erro_produto} !== 3'b000) begin n_err++; $display("FAIL rst_async: estado=%0d credito=%0d codigo=%0d troco=%0d pulses=%b required 0/0/0/0/000", estado, credito, codigo_produto, troco, {liberar_produto, troco_valido, erro_produto}); end
        tick();
        rst = 1'b0;
        tick();
        n_cmp++; if (troco_valido !== 1'b0 || troco !== 5'd0 || estado !== 2'b00) begin n_err++; $display("FAIL rst_sem_troco: tv=%b troco=%0d estado=%0d required 0/0/0", troco_valido, troco, estado); end
        codigo_in = 4'b0100; selecionar = 1'b1;
        tick();
        selecionar = 1'b0;
        n_cmp++; if (estado !== 2'b01) begin n_err++; $display("FAIL rst_retoma: estado=%0d required 1", estado); end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
        test_compra_exata();
        test_troco();
        test_produto_inexistente();
        test_cancelar();
        test_timeout();
        test_preco_zero();
        test_moedas_ignoradas();
        test_credito_maximo();
        test_back_to_back();
        test_reset_meio();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
